// File: rtl/ram_pkg.sv
// Shared types and constants for the single-port synchronous RAM controller.
package ram_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_CLEAR = 1'b1;

    localparam int RW_READ_FIRST  = 0;
    localparam int RW_WRITE_FIRST = 1;

    function automatic int byte_lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// Clear sequencer: sweeps every address once after reset or on a clr request.
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    output logic              busy_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    // Terminal count is DEPTH-1, i.e. the all-ones address.
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                // clr is deliberately ignored here so a running sweep is never restarted.
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_o     = busy_q;
    assign clr_we_o   = (state_q == ST_CLEAR);
    assign clr_addr_o = cnt_q;

endmodule

// File: rtl/sp_sync_ram_ctrl.sv
// Single-port synchronous RAM with registered read, byte enables, collision mode
// and a self-clearing sweep after reset or on request.
module sp_sync_ram_ctrl
    import ram_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 10,
    parameter int                RW_MODE  = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cs,
    input  logic                     read,
    input  logic                     write,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [byte_lanes(DATA_W)-1:0] be,
    input  logic                     clr,
    output logic [DATA_W-1:0]        rdata,
    output logic                     rvalid,
    output logic                     busy
);

    localparam int LANES = byte_lanes(DATA_W);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q;

    logic              busy_w;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              accept, wr_en, rd_en;
    logic [DATA_W-1:0] old_word, merged_word;

    ram_clear_fsm #(
        .ADDR_W(ADDR_W)
    ) u_clear_fsm (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (clr),
        .busy_o    (busy_w),
        .clr_we_o  (clr_we),
        .clr_addr_o(clr_addr)
    );

    assign accept   = cs && !busy_w && !rst;
    assign wr_en    = accept && write;
    assign rd_en    = accept && read;
    assign old_word = mem_q[addr];

    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (be[i]) merged_word[8*i +: 8] = wdata[8*i +: 8];
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = (RW_MODE == RW_WRITE_FIRST && write) ? merged_word : old_word;
        end
    end

    // NOTE: the array has no reset; the clear sweep is what initialises it, and a reset would block RAM inference.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= INIT_VAL;
        end else if (wr_en) begin
            mem_q[addr] <= merged_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rd_en;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign busy   = busy_w;

endmodule

// File: tb/tb_sp_sync_ram_ctrl.sv
// Drives READ_FIRST and WRITE_FIRST instances in lockstep and compares both
// against a word-array reference model of the access and clear rules.
module tb_sp_sync_ram_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam logic [DATA_W-1:0] INIT_VAL = '0;

    logic              clk = 1'b0;
    logic              rst, cs, read, write, clr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        be;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              rvalid0, rvalid1, busy0, busy1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [DATA_W-1:0] mem_m [DEPTH];
    int                busy_left = 0;
    logic [DATA_W-1:0] exp_rd0 = '0, exp_rd1 = '0;
    logic              exp_rv = 1'b0;

    always #5 clk = ~clk;

    sp_sync_ram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RW_MODE(0), .INIT_VAL(INIT_VAL)) dut0 (
        .clk(clk), .rst(rst), .cs(cs), .read(read), .write(write), .addr(addr),
        .wdata(wdata), .be(be), .clr(clr), .rdata(rdata0), .rvalid(rvalid0), .busy(busy0)
    );

    sp_sync_ram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RW_MODE(1), .INIT_VAL(INIT_VAL)) dut1 (
        .clk(clk), .rst(rst), .cs(cs), .read(read), .write(write), .addr(addr),
        .wdata(wdata), .be(be), .clr(clr), .rdata(rdata1), .rvalid(rvalid1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = INIT_VAL;
        busy_left = DEPTH;
    endtask

    task automatic model_edge(input logic r, input logic c, input logic rd, input logic wr,
                              input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                              input logic [1:0] b, input logic cl);
        logic [DATA_W-1:0] old_w, new_w;
        if (r) begin
            model_clear();
            exp_rd0 = '0;
            exp_rd1 = '0;
            exp_rv  = 1'b0;
        end else if (busy_left > 0) begin
            busy_left--;
            exp_rv = 1'b0;
        end else begin
            exp_rv = c && rd;
            if (c) begin
                old_w = mem_m[a];
                new_w = old_w;
                if (b[0]) new_w[7:0]  = wd[7:0];
                if (b[1]) new_w[15:8] = wd[15:8];
                if (rd) begin
                    exp_rd0 = old_w;
                    exp_rd1 = wr ? new_w : old_w;
                end
                if (wr) mem_m[a] = new_w;
            end
            if (cl) model_clear();
        end
    endtask

    task automatic step(input string tag, input logic r, input logic c, input logic rd,
                        input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] wd, input logic [1:0] b, input logic cl);
        rst = r; cs = c; read = rd; write = wr; addr = a; wdata = wd; be = b; clr = cl;
        model_edge(r, c, rd, wr, a, wd, b, cl);
        @(posedge clk);
        #1;
        check({tag, " busy0"},   {31'd0, busy0},   {31'd0, busy_left > 0});
        check({tag, " busy1"},   {31'd0, busy1},   {31'd0, busy_left > 0});
        check({tag, " rvalid0"}, {31'd0, rvalid0}, {31'd0, exp_rv});
        check({tag, " rvalid1"}, {31'd0, rvalid1}, {31'd0, exp_rv});
        check({tag, " rdata0"},  {16'd0, rdata0},  {16'd0, exp_rd0});
        check({tag, " rdata1"},  {16'd0, rdata1},  {16'd0, exp_rd1});
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0; clr = 1'b0;
        addr = '0; wdata = '0; be = '0;
        @(negedge clk);

        // Reset and initial sweep, with a read attempt that must be dropped.
        step("reset", 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
        for (int i = 0; i < DEPTH - 1; i++) step("sweep_rd", 1'b0, 1'b1, 1'b1, 1'b0, 4'(i), '0, 2'b00, 1'b0);
        step("sweep_end", 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, '0, 2'b00, 1'b0);
        check("busy_low_after_sweep", {31'd0, busy0}, 32'd0);

        // Back-to-back reads of every address after clear.
        for (int i = 0; i < DEPTH; i++) step("init_read", 1'b0, 1'b1, 1'b1, 1'b0, 4'(i), '0, 2'b00, 1'b0);
        idle("init_read_idle");

        // Full write then read, rdata holds afterwards.
        step("wr3", 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 16'hABCD, 2'b11, 1'b0);
        step("rd3", 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, '0, 2'b00, 1'b0);
        check("rd3_value", {16'd0, rdata0}, 32'h0000ABCD);
        idle("rd3_hold");
        check("rd3_hold_value", {16'd0, rdata0}, 32'h0000ABCD);

        // Byte-enable merge.
        step("wr5_full", 1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 16'h1234, 2'b11, 1'b0);
        step("wr5_hi",   1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 16'hFF00, 2'b10, 1'b0);
        step("wr5_none", 1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 16'h5555, 2'b00, 1'b0);
        step("rd5",      1'b0, 1'b1, 1'b1, 1'b0, 4'd5, '0, 2'b00, 1'b0);
        check("rd5_value", {16'd0, rdata1}, 32'h0000FF34);

        // Read/write collision in both modes.
        step("wr7",      1'b0, 1'b1, 1'b0, 1'b1, 4'd7, 16'h1111, 2'b11, 1'b0);
        step("coll7",    1'b0, 1'b1, 1'b1, 1'b1, 4'd7, 16'h2222, 2'b11, 1'b0);
        check("coll7_read_first",  {16'd0, rdata0}, 32'h00001111);
        check("coll7_write_first", {16'd0, rdata1}, 32'h00002222);
        step("coll7_lo", 1'b0, 1'b1, 1'b1, 1'b1, 4'd7, 16'h00EE, 2'b01, 1'b0);
        step("rd7",      1'b0, 1'b1, 1'b1, 1'b0, 4'd7, '0, 2'b00, 1'b0);
        idle("rd7_idle");

        // clr in IDLE, writes during busy are dropped.
        step("clr", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b1);
        for (int i = 0; i < DEPTH; i++) step("busy_wr2", 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 16'hBEEF, 2'b11, 1'b0);
        step("rd2", 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, '0, 2'b00, 1'b0);
        check("rd2_dropped", {16'd0, rdata0}, 32'h00000000);

        // Access with clr in the same cycle, then reset mid-sweep with clr pulses.
        step("wr9_clr", 1'b0, 1'b1, 1'b1, 1'b1, 4'd9, 16'h9999, 2'b11, 1'b1);
        for (int i = 0; i < 8; i++) idle("sweep_pre_rst");
        step("rst_mid", 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b1);
        for (int i = 0; i < DEPTH; i++) step("rst_sweep", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 2'b00, 1'(i % 3 == 0));
        step("rd9", 1'b0, 1'b1, 1'b1, 1'b0, 4'd9, '0, 2'b00, 1'b0);

        // Randomised traffic with occasional clear and reset.
        for (int i = 0; i < 800; i++) begin
            step("rand",
                 1'($urandom_range(0, 299) == 0),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, DEPTH - 1)),
                 16'($urandom),
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 99) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sp_sync_ram_ctrl.md
Name: sp_sync_ram_ctrl

Overview:
Parametrised single-port synchronous RAM. It adds a registered read with a valid strobe, byte-enable writes, and a defined collision mode. A built-in clear sequencer sweeps the array to a fixed value after reset or on request. It serves as the general-purpose on-chip buffer for datapath blocks that need deterministic, initialised storage with one-cycle read latency.

Parameters:
DATA_W, 16, word width in bits; must be a multiple of 8
ADDR_W, 10, address width; DEPTH = 2**ADDR_W words (1024 by default)
RW_MODE, 0, read/write collision mode: 0 = READ_FIRST (old data returned), 1 = WRITE_FIRST (new merged data returned)
INIT_VAL, 0, DATA_W-bit value written to every word by the clear sequence

Ports:
clk  in  1  single clock; all state changes on its rising edge
rst  in  1  synchronous, active-high reset
cs  in  1  chip select; no access is performed when low
read  in  1  read request, qualified by cs
write  in  1  write request, qualified by cs
addr  in  ADDR_W  word address
wdata  in  DATA_W  write data
be  in  DATA_W/8  byte enables; be[i] gates wdata[8i+7:8i]
clr  in  1  one-cycle request to re-run the clear sweep
rdata  out  DATA_W  registered read data; holds its value until the next accepted read
rvalid  out  1  one-cycle pulse, asserted the cycle after an accepted read
busy  out  1  high while the clear sweep is running; accesses are ignored while high

Behaviour:
- Reset (rst=1 at a clk edge): FSM moves to CLEAR, clear counter to 0, rdata to 0, rvalid to 0, busy to 1. rst overrides clr and any access. Reset mid-sweep restarts the sweep at address 0.
- FSM states: IDLE and CLEAR.
  - CLEAR: each cycle writes INIT_VAL to mem[cnt] (all bytes) and increments cnt.
  - When cnt == DEPTH-1, that final word is written, the FSM moves to IDLE, and busy drops the following cycle.
  - A sweep therefore takes exactly DEPTH cycles with busy=1.
  - IDLE to CLEAR occurs when clr=1; cnt is reset to 0 and busy rises the next cycle.
  - clr while already in CLEAR is ignored; it does not restart the sweep.
- Access acceptance: an access is accepted only in IDLE with busy=0 and cs=1. Requests made while busy are dropped silently: no write occurs and no rvalid is produced.
- Write: if cs&write, each byte i with be[i]=1 is updated at mem[addr] at the clk edge. Bytes with be[i]=0 are unchanged. be=0 is a legal no-op write.
- Read: if cs&read, rdata is loaded at the clk edge and rvalid=1 for exactly the next cycle. Read latency is 1 cycle. Back-to-back reads on consecutive cycles give rvalid high continuously.
- read&write together at the same address are both performed.
  - RW_MODE=0: rdata = the pre-write word.
  - RW_MODE=1: rdata = the post-write merged word, including unchanged bytes.
- clr in the same cycle as an accepted access: the access completes (write lands, rvalid produced) and the sweep starts next cycle. The sweep will later overwrite that write.
- Counter is ADDR_W bits and does not wrap: the terminal compare is at DEPTH-1. addr is used unmodified, so there is no out-of-range case.
- Memory contents are undefined only before the first reset. After any sweep, every word equals INIT_VAL.

Decomposition:
- Shared package ram_pkg: state type (IDLE, CLEAR), RW_MODE constants (RW_READ_FIRST=0, RW_WRITE_FIRST=1), helper function for the byte-lane count DATA_W/8.
- One natural sub-module, ram_clear_fsm: owns the state register, clear counter, busy flag and the terminal-count compare. It outputs the clear write enable and clear address to the array/mux in the top.

Test Plan:
- DATA_W=16, ADDR_W=4: assert rst 1 cycle -> busy=1 for exactly 16 cycles, rvalid=0 throughout; then reading all 16 addresses returns 0x0000 (INIT_VAL=0), each with one rvalid pulse one cycle after the request.
- After clear: write addr=3, wdata=0xABCD, be=2'b11; next cycle read addr=3 -> cycle+1 rdata=0xABCD, rvalid=1; following idle cycle rvalid=0, rdata holds 0xABCD.
- Byte enables: write addr=5 wdata=0x1234 be=11; write addr=5 wdata=0xFF00 be=2'b10 -> read returns 0xFF34.
- Collision at addr=7 holding 0x1111, read&write wdata=0x2222 be=11: RW_MODE=0 -> rdata=0x1111; RW_MODE=1 -> rdata=0x2222; subsequent read -> 0x2222 in both modes.
- clr pulse in IDLE, then write addr=2 during busy -> busy=1 for 16 cycles, no rvalid; after busy drops, read addr=2 -> 0x0000 (dropped write).
- rst asserted at sweep cycle 9 -> sweep restarts at 0; busy stays high 16 further cycles; clr pulses during busy do not extend it.
